// File: rtl/bus_source_sel.sv
// Read-side bus source selector: latches a register code and drives the
// selected datapath register onto a registered shared bus.
module bus_source_sel #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       sel,
  input  logic             EN_OP,
  input  logic             EN_OUT,
  input  logic [W-1:0]     str_pointer_q,
  input  logic [W-1:0]     mar_q,
  input  logic [W-1:0]     mdr_q,
  input  logic [W-1:0]     pr1_q,
  input  logic [W-1:0]     pr2_q,
  input  logic [W-1:0]     pr3_q,
  input  logic [W-1:0]     col_q,
  input  logic [W-1:0]     row_q,
  input  logic [W-1:0]     r1_q,
  input  logic [W-1:0]     r2_q,
  input  logic [W-1:0]     mem_data,
  output logic [W-1:0]     bus,
  output logic             bus_valid,
  output logic [3:0]       sel_q,
  output logic             sel_err,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SELECTED,
    DRIVE
  } state_t;

  state_t state_q;

  logic [W-1:0] src_tbl [16];
  logic [3:0]   eff_code;
  logic [W-1:0] eff_src;
  logic [W-1:0] lock_src;
  logic         eff_ok;
  logic         sel_ok;

  function automatic logic legal(input logic [3:0] c);
    return !(c == 4'b0000 || c == 4'b0011 || c >= 4'b1101);
  endfunction

  // Same code map as the destination decoder; illegal slots read as zero.
  always_comb begin
    for (int i = 0; i < 16; i++) src_tbl[i] = '0;
    src_tbl[1]  = str_pointer_q;
    src_tbl[2]  = mem_data;
    src_tbl[4]  = mar_q;
    src_tbl[5]  = mdr_q;
    src_tbl[6]  = pr1_q;
    src_tbl[7]  = pr2_q;
    src_tbl[8]  = pr3_q;
    src_tbl[9]  = col_q;
    src_tbl[10] = row_q;
    src_tbl[11] = r1_q;
    src_tbl[12] = r2_q;
  end

  // A same-cycle EN_OP bypasses the latched code.
  assign eff_code = EN_OP ? sel : sel_q;
  assign eff_src  = src_tbl[eff_code];
  assign eff_ok   = legal(eff_code);
  assign sel_ok   = legal(sel);
  assign lock_src = src_tbl[sel_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bus       <= '0;
      bus_valid <= 1'b0;
      sel_q     <= 4'b0000;
      sel_err   <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (EN_OP) begin
            sel_q   <= sel;
            sel_err <= !sel_ok;
            state_q <= SELECTED;
          end
        end
        SELECTED: begin
          if (EN_OP) begin
            sel_q   <= sel;
            sel_err <= !sel_ok;
          end
          if (EN_OUT) begin
            if (eff_ok) begin
              bus       <= eff_src;
              bus_valid <= 1'b1;
              state_q   <= DRIVE;
            end else begin
              bus <= '0;
            end
          end
        end
        DRIVE: begin
          if (EN_OUT) begin
            bus <= lock_src;
          end else begin
            bus_valid <= 1'b0;
            xfer_cnt  <= xfer_cnt + CNT_W'(1);
            state_q   <= SELECTED;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_source_sel.sv
// Bench for bus_source_sel: directed vector table, hand sequences
// and randomized traffic against a transfer-level reference model.
module tb_bus_source_sel;

  localparam int W     = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       sel;
  logic             EN_OP;
  logic             EN_OUT;
  logic [W-1:0]     rv [16];
  logic [W-1:0]     bus;
  logic             bus_valid;
  logic [3:0]       sel_q;
  logic             sel_err;
  logic [CNT_W-1:0] xfer_cnt;

  always #5 clk = ~clk;

  bus_source_sel #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .sel(sel),
    .EN_OP(EN_OP),
    .EN_OUT(EN_OUT),
    .str_pointer_q(rv[1]),
    .mar_q(rv[4]),
    .mdr_q(rv[5]),
    .pr1_q(rv[6]),
    .pr2_q(rv[7]),
    .pr3_q(rv[8]),
    .col_q(rv[9]),
    .row_q(rv[10]),
    .r1_q(rv[11]),
    .r2_q(rv[12]),
    .mem_data(rv[2]),
    .bus(bus),
    .bus_valid(bus_valid),
    .sel_q(sel_q),
    .sel_err(sel_err),
    .xfer_cnt(xfer_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: which codes name a register, plus transfer bookkeeping.
  localparam logic [15:0] LEGAL = 16'h1FF6;
  bit               m_have_sel;
  bit               m_driving;
  logic [W-1:0]     m_bus;
  logic             m_valid;
  logic [3:0]       m_selq;
  logic             m_err;
  int               m_xfers;

  task automatic model_step();
    logic [3:0] code;
    if (rst) begin
      m_have_sel = 0;
      m_driving  = 0;
      m_bus      = '0;
      m_valid    = 1'b0;
      m_selq     = 4'd0;
      m_err      = 1'b0;
      m_xfers    = 0;
    end else if (m_driving) begin
      if (EN_OUT) m_bus = rv[m_selq];
      else begin
        m_driving = 0;
        m_valid   = 1'b0;
        m_xfers++;
      end
    end else begin
      code = EN_OP ? sel : m_selq;
      if (EN_OP) begin
        m_selq = sel;
        m_err  = !LEGAL[sel];
      end
      if (m_have_sel && EN_OUT) begin
        if (LEGAL[code]) begin
          m_bus     = rv[code];
          m_valid   = 1'b1;
          m_driving = 1;
        end else begin
          m_bus = '0;
        end
      end
      if (EN_OP) m_have_sel = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".bus"}, 32'(bus), 32'(m_bus));
    chk({tag, ".valid"}, 32'(bus_valid), 32'(m_valid));
    chk({tag, ".sel_q"}, 32'(sel_q), 32'(m_selq));
    chk({tag, ".sel_err"}, 32'(sel_err), 32'(m_err));
    chk({tag, ".cnt"}, 32'(xfer_cnt), 32'(m_xfers % 256));
  endtask

  task automatic cyc(input logic r, input logic op, input logic out,
                     input logic [3:0] s);
    rst    = r;
    EN_OP  = op;
    EN_OUT = out;
    sel    = s;
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       r;
    logic       op;
    logic       out;
    logic [3:0] s;
    logic [15:0] e_bus;
    logic       e_v;
    logic [3:0] e_selq;
    logic       e_err;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vt [19];

  initial begin
    rst = 1'b1; EN_OP = 1'b0; EN_OUT = 1'b0; sel = 4'd0;
    for (int i = 0; i < 16; i++) rv[i] = 16'(i * 16'h1111);
    rv[1]  = 16'h1111;
    rv[5]  = 16'hA5C3;
    rv[11] = 16'hBBBB;
    rv[12] = 16'h0F0F;

    //        r  op out sel   bus       v  selq  err cnt
    vt[0]  = '{1, 0, 0, 4'h0, 16'h0000, 0, 4'h0, 0, 8'd0};
    vt[1]  = '{0, 0, 1, 4'h0, 16'h0000, 0, 4'h0, 0, 8'd0};
    vt[2]  = '{0, 1, 0, 4'h5, 16'h0000, 0, 4'h5, 0, 8'd0};
    vt[3]  = '{0, 0, 1, 4'h0, 16'hA5C3, 1, 4'h5, 0, 8'd0};
    vt[4]  = '{0, 0, 1, 4'h0, 16'hA5C3, 1, 4'h5, 0, 8'd0};
    vt[5]  = '{0, 0, 1, 4'h0, 16'hA5C3, 1, 4'h5, 0, 8'd0};
    vt[6]  = '{0, 0, 0, 4'h0, 16'hA5C3, 0, 4'h5, 0, 8'd1};
    vt[7]  = '{0, 1, 0, 4'hB, 16'hA5C3, 0, 4'hB, 0, 8'd1};
    vt[8]  = '{0, 1, 1, 4'hC, 16'h0F0F, 1, 4'hC, 0, 8'd1};
    vt[9]  = '{0, 0, 0, 4'h0, 16'h0F0F, 0, 4'hC, 0, 8'd2};
    vt[10] = '{0, 1, 0, 4'hE, 16'h0F0F, 0, 4'hE, 1, 8'd2};
    vt[11] = '{0, 0, 1, 4'h0, 16'h0000, 0, 4'hE, 1, 8'd2};
    vt[12] = '{0, 0, 1, 4'h0, 16'h0000, 0, 4'hE, 1, 8'd2};
    vt[13] = '{0, 1, 0, 4'h1, 16'h0000, 0, 4'h1, 0, 8'd2};
    vt[14] = '{0, 1, 1, 4'h3, 16'h0000, 0, 4'h3, 1, 8'd2};
    vt[15] = '{0, 1, 1, 4'h1, 16'h1111, 1, 4'h1, 0, 8'd2};
    vt[16] = '{1, 0, 1, 4'h0, 16'h0000, 0, 4'h0, 0, 8'd0};
    vt[17] = '{0, 0, 1, 4'h0, 16'h0000, 0, 4'h0, 0, 8'd0};
    vt[18] = '{0, 0, 1, 4'h7, 16'h0000, 0, 4'h0, 0, 8'd0};

    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      cyc(vt[i].r, vt[i].op, vt[i].out, vt[i].s);
      chk($sformatf("vec%0d.bus", i), 32'(bus), 32'(vt[i].e_bus));
      chk($sformatf("vec%0d.valid", i), 32'(bus_valid), 32'(vt[i].e_v));
      chk($sformatf("vec%0d.sel_q", i), 32'(sel_q), 32'(vt[i].e_selq));
      chk($sformatf("vec%0d.sel_err", i), 32'(sel_err), 32'(vt[i].e_err));
      chk($sformatf("vec%0d.cnt", i), 32'(xfer_cnt), 32'(vt[i].e_cnt));
    end

    // Tracking and lock during DRIVE.
    rv[6] = 16'h0001;
    rv[7] = 16'h7777;
    cyc(1, 0, 0, 4'h0);
    cyc(0, 1, 0, 4'h6);
    cyc(0, 0, 1, 4'h0);
    chk("track.first", 32'(bus), 32'h0001);
    rv[6] = 16'h0002;
    cyc(0, 1, 1, 4'h7);
    chk("track.follow", 32'(bus), 32'h0002);
    chk("track.lock", 32'(sel_q), 32'h6);
    chk("track.valid", 32'(bus_valid), 32'h1);
    cyc(0, 0, 0, 4'h0);
    chk("track.cnt", 32'(xfer_cnt), 32'd1);
    chk("track.hold", 32'(bus), 32'h0002);

    // Reset in the middle of a transfer drops it from the count.
    cyc(0, 0, 1, 4'h0);
    chk("rstmid.pre", 32'(bus_valid), 32'h1);
    cyc(1, 0, 1, 4'h0);
    chk("rstmid.bus", 32'(bus), 32'h0);
    chk("rstmid.cnt", 32'(xfer_cnt), 32'd0);
    chk("rstmid.selq", 32'(sel_q), 32'h0);
    cyc(0, 0, 1, 4'h0);
    chk("rstmid.idle", 32'(bus_valid), 32'h0);

    // Counter wrap after 256 single-cycle transfers.
    cyc(0, 1, 0, 4'h9);
    for (int t = 1; t <= 256; t++) begin
      cyc(0, 0, 1, 4'h0);
      cyc(0, 0, 0, 4'h0);
      if (t == 255) chk("wrap.255", 32'(xfer_cnt), 32'd255);
    end
    chk("wrap.zero", 32'(xfer_cnt), 32'd0);
    chk_model("wrap");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0)
        for (int k = 0; k < 16; k++) rv[k] = 16'($urandom);
      cyc($urandom_range(59) == 0, $urandom_range(3) == 0,
          $urandom_range(2) != 0, 4'($urandom_range(15)));
      chk_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
